pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 25, operand and sum width; legal range 4..64.
REQ-002 SHALL have parameter GROUP, default 4, level-1 lookahead group size; legal values 2, 3, 4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in1  input  WIDTH  first operand.
REQ-008 SHALL have port in2  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  1 = in1-in2, 0 = in1+in2.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port S  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 SHALL have port Cout  output  1  carry out of MSB (for sub: 1 = no borrow).

Function
REQ-014 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-015 SHALL split the operands into ceil(WIDTH/GROUP) groups, with the last group taking the remainder bits, and compute bit p=a^b, g=a&b.
REQ-016 SHALL register in stage 1: bit p, group pout/gout, and carry-in (cin = sub).
REQ-017 SHALL resolve group carries in stage 2 via a second lookahead level, then compute S = p ^ c and Cout = final group-carry.
REQ-018 SHALL register S/Cout in stage 2; latency = exactly 2 cycles from acceptance to out_valid with no stall.
REQ-019 SHALL sustain 1 beat per cycle when out_ready is held 1.
REQ-020 SHALL make each stage advance only when it is empty or the next stage advances; in_ready = !s1_valid || s2_advance.
REQ-021 SHALL hold S, Cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous output pop and input push with both stages full, shift both stages with no bubble and no loss.
REQ-023 SHALL NOT change stage registers when their valid bit is 0 and nothing enters; data content while invalid is don't-care.
REQ-024 SHALL, with sub=1, use in2 inverted and cin=1 (two's-complement subtraction).

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-stream), asynchronously clear s1_valid, s2_valid and out_valid, and set S = 0 and Cout = 0.
REQ-026 SHALL discard in-flight beats on reset; in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-027 SHALL, with macro PIPE_CLA_SUB_EN defined, implement sub per REQ-024.
REQ-028 SHALL, without PIPE_CLA_SUB_EN, keep port sub but ignore it: cin=0, in2 not inverted, add only.

Structure
REQ-029 SHALL place in shared package cla_pkg: constant CLA_MAX_GROUP=4, function cla_ngroups(width, group), and typedef for the group p/g pair.
REQ-030 SHALL implement one sub-module, cla_group (parameter N = 2..4; ports p, g, c, pout, gout, cout), instantiated in both lookahead levels.

Verification (WIDTH=25, GROUP=4 unless stated)
REQ-031 SHALL cover 0x1FFFFFF + 0x0000001, sub=0 -> S=0x0000000, Cout=1, out_valid exactly 2 cycles after acceptance.
REQ-032 SHALL cover 0x0000005 - 0x0000007, sub=1 with PIPE_CLA_SUB_EN -> S=0x1FFFFFE, Cout=0; same stimulus without the macro -> S=0x000000C, Cout=0.
REQ-033 SHALL cover 3 back-to-back beats with out_ready held 0 for 4 cycles -> in_ready falls after 2 beats, third beat waits, results are in order with no duplicates once out_ready=1.
REQ-034 SHALL cover rst_n pulsed low while 2 beats are in flight -> out_valid=0, S=0, Cout=0 immediately, no stale beat after release.
REQ-035 SHALL cover WIDTH=10, GROUP=3, random 10k beats with random out_ready -> every S/Cout matches the reference model {Cout,S} = in1 + (sub ? ~in2+1 : in2).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions: group size limit, group count helper
// and the propagate/generate pair carried between lookahead levels.
package cla_pkg;

  localparam int CLA_MAX_GROUP = 4;

  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic int cla_ngroups(input int width, input int group);
    return (width + group - 1) / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// N-bit lookahead block: group propagate/generate plus the carry out of every
// position, each carry expanded directly from c rather than rippled.
module cla_group #(
  parameter int N = 4
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         c,
  output logic         pout,
  output logic         gout,
  output logic [N-1:0] cout
);

  always_comb begin
    pout = &p;
    gout = 1'b0;
    for (int i = 0; i < N; i++) begin
      gout = g[i] | (p[i] & gout);
    end
  end

  always_comb begin
    logic acc_g;
    logic acc_p;
    cout  = '0;
    acc_g = 1'b0;
    acc_p = 1'b1;
    for (int i = 0; i < N; i++) begin
      acc_g   = 1'b0;
      acc_p   = 1'b1;
      for (int j = 0; j <= i; j++) begin
        acc_g = g[j] | (p[j] & acc_g);
        acc_p = acc_p & p[j];
      end
      cout[i] = acc_g | (acc_p & c);
    end
  end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow.
// Subtraction via the sub port is honoured only when PIPE_CLA_SUB_EN is defined.
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NG = cla_ngroups(WIDTH, GROUP);
  localparam int PW = NG * GROUP;
  localparam int NS = cla_ngroups(NG, CLA_MAX_GROUP);
  localparam int PS = NS * CLA_MAX_GROUP;

  logic [WIDTH-1:0] b_eff;
  logic             cin_d;

`ifdef PIPE_CLA_SUB_EN
  assign b_eff = sub ? ~in2 : in2;
  assign cin_d = sub;
`else
  assign b_eff = in2;
  assign cin_d = 1'b0;
`endif

  // Pad the short last group with p=1/g=0 so it passes its carry straight through.
  logic [PW-1:0] p_d, g_d;
  always_comb begin
    p_d            = '1;
    g_d            = '0;
    p_d[WIDTH-1:0] = in1 ^ b_eff;
    g_d[WIDTH-1:0] = in1 & b_eff;
  end

  cla_pg_t [NG-1:0] grp_d;
  logic    [PW-1:0] unused_l1_cout;

  for (genvar k = 0; k < NG; k++) begin : g_l1
    cla_group #(.N(GROUP)) u_grp (
      .p    (p_d[k*GROUP +: GROUP]),
      .g    (g_d[k*GROUP +: GROUP]),
      .c    (1'b0),
      .pout (grp_d[k].p),
      .gout (grp_d[k].g),
      .cout (unused_l1_cout[k*GROUP +: GROUP])
    );
  end

  // Valid/ready: a beat moves across an interface in any cycle where valid and
  // ready are both 1; a stage advances when it is empty or its successor advances.
  logic s1_valid, s2_valid, s2_advance, s1_load, s2_load;
  assign s2_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign s1_load    = in_valid && in_ready;
  assign s2_load    = s1_valid && s2_advance;
  assign out_valid  = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)         s1_valid <= 1'b1;
      else if (s2_advance) s1_valid <= 1'b0;
      if (s2_advance)      s2_valid <= s1_valid;
    end
  end

  logic    [PW-1:0] s1_p, s1_g;
  cla_pg_t [NG-1:0] s1_grp;
  logic             s1_cin;

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p   <= p_d;
      s1_g   <= g_d;
      s1_grp <= grp_d;
      s1_cin <= cin_d;
    end
  end

  logic [PS-1:0] sp, sg;
  always_comb begin
    sp = '1;
    sg = '0;
    for (int k = 0; k < NG; k++) begin
      sp[k] = s1_grp[k].p;
      sg[k] = s1_grp[k].g;
    end
  end

  // Second level: super-groups of group p/g, chained by their carry out.
  logic [PS-1:0] gcout;
  logic [NS:0]   sc;
  logic [NS-1:0] unused_sp, unused_sg;
  assign sc[0] = s1_cin;

  for (genvar j = 0; j < NS; j++) begin : g_l2
    cla_group #(.N(CLA_MAX_GROUP)) u_sgrp (
      .p    (sp[j*CLA_MAX_GROUP +: CLA_MAX_GROUP]),
      .g    (sg[j*CLA_MAX_GROUP +: CLA_MAX_GROUP]),
      .c    (sc[j]),
      .pout (unused_sp[j]),
      .gout (unused_sg[j]),
      .cout (gcout[j*CLA_MAX_GROUP +: CLA_MAX_GROUP])
    );
    assign sc[j+1] = gcout[j*CLA_MAX_GROUP + CLA_MAX_GROUP - 1];
  end

  logic [NG-1:0] gc;
  always_comb begin
    gc    = '0;
    gc[0] = s1_cin;
    for (int k = 1; k < NG; k++) gc[k] = gcout[k-1];
  end

  logic [PW-1:0] bc;
  logic [NG-1:0] unused_bp, unused_bg;

  for (genvar k = 0; k < NG; k++) begin : g_bits
    cla_group #(.N(GROUP)) u_bgrp (
      .p    (s1_p[k*GROUP +: GROUP]),
      .g    (s1_g[k*GROUP +: GROUP]),
      .c    (gc[k]),
      .pout (unused_bp[k]),
      .gout (unused_bg[k]),
      .cout (bc[k*GROUP +: GROUP])
    );
  end

  logic [PW-1:0] ci;
  always_comb begin
    ci    = '0;
    ci[0] = s1_cin;
    for (int i = 1; i < PW; i++) ci[i] = bc[i-1];
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             unused_bits;
  assign sum_d       = s1_p[WIDTH-1:0] ^ ci[WIDTH-1:0];
  assign cout_d      = sc[NS];
  assign unused_bits = ^{s1_p, ci, bc, gcout, sub};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else if (s2_load) begin
      S    <= sum_d;
      Cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed bench for pipe_cla_addsub (25/4 instance) plus a 10/3 instance
// driven with random operands and random back-pressure against a reference sum.
module tb_pipe_cla_addsub;

`ifdef PIPE_CLA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int NB = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, sub, out_ready;
  logic [24:0] in1, in2;
  logic        in_ready, out_valid, Cout;
  logic [24:0] S;

  logic        in_valid10, sub10, out_ready10;
  logic [9:0]  in1_10, in2_10;
  logic        in_ready10, out_valid10, Cout10;
  logic [9:0]  S10;

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];
  logic [10:0] exp_q10[$];

  always #5 clk = ~clk;

  pipe_cla_addsub #(.WIDTH(25), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .Cout(Cout)
  );

  pipe_cla_addsub #(.WIDTH(10), .GROUP(3)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
    .in1(in1_10), .in2(in2_10), .sub(sub10), .out_valid(out_valid10),
    .out_ready(out_ready10), .S(S10), .Cout(Cout10)
  );

  function automatic logic [25:0] ref25(input logic [24:0] a, input logic [24:0] b, input logic s);
    if (s && SUB_EN) return {1'b0, a} + {1'b0, ~b} + 26'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [10:0] ref10(input logic [9:0] a, input logic [9:0] b, input logic s);
    if (s && SUB_EN) return {1'b0, a} + {1'b0, ~b} + 11'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (S !== 25'h0) begin errors++; $display("FAIL reset_S got %h want 0", S); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout got %b want 0", Cout); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  // Offers one beat, then counts cycles until out_valid and checks the result.
  task automatic run_single(input string name, input logic [24:0] a, input logic [24:0] b,
                            input logic s, input logic [24:0] exp_s, input logic exp_c);
    int lat;
    @(negedge clk);
    in1 = a; in2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready got %b want 1", name, in_ready); end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      #1;
      if (out_valid) break;
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL %s_latency got %0d want 2", name, lat); end
    checks++; if (S !== exp_s) begin errors++; $display("FAIL %s_S got %h want %h", name, S, exp_s); end
    checks++; if (Cout !== exp_c) begin errors++; $display("FAIL %s_Cout got %b want %b", name, Cout, exp_c); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain out_valid got %b want 0", name, out_valid); end
  endtask

  task automatic test_add_carry;
    run_single("add_wrap", 25'h1FFFFFF, 25'h0000001, 1'b0, 25'h0000000, 1'b1);
  endtask

  task automatic test_sub;
    run_single("sub_5_7", 25'h0000005, 25'h0000007, 1'b1,
               SUB_EN ? 25'h1FFFFFE : 25'h000000C, 1'b0);
    run_single("sub_9_3", 25'h0000009, 25'h0000003, 1'b1,
               SUB_EN ? 25'h0000006 : 25'h000000C, SUB_EN);
    run_single("sub_x_0", 25'h0000123, 25'h0000000, 1'b1, 25'h0000123, SUB_EN);
    run_single("sub_eq", 25'h1000000, 25'h1000000, 1'b1, 25'h0000000, 1'b1);
  endtask

  task automatic test_directed;
    run_single("add_mix", 25'h0ABCDEF, 25'h1234567, 1'b0, 25'h1CF1356, 1'b0);
    run_single("add_prop", 25'h1555555, 25'h0AAAAAA, 1'b0, 25'h1FFFFFF, 1'b0);
    run_single("add_max", 25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 25'h1FFFFFE, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [24:0] va[3];
    logic [24:0] vb[3];
    logic [25:0] exp;
    int sent, got;
    va[0] = 25'h0000001; vb[0] = 25'h0000002;
    va[1] = 25'h1FFFFFF; vb[1] = 25'h1FFFFFF;
    va[2] = 25'h0123456; vb[2] = 25'h0000010;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 3);
      sub       = 1'b0;
      if (sent < 3) begin in1 = va[sent]; in2 = vb[sent]; end
      #1;
      if (cyc <= 3) begin
        checks++;
        if (in_ready !== (cyc < 2)) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, cyc < 2); end
      end
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (out_valid !== 1'b1 || {Cout, S} !== 26'h0000003) begin
          errors++; $display("FAIL b2b_hold cyc %0d got v=%b %h want v=1 0000003", cyc, out_valid, {Cout, S});
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got %h want none", {Cout, S}); end
        else begin
          exp = exp_q.pop_front();
          if ({Cout, S} !== exp) begin errors++; $display("FAIL b2b_data got %h want %h", {Cout, S}, exp); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref25(in1, in2, sub));
        sent++;
      end
    end
    checks++; if (got !== 3 || sent !== 3) begin errors++; $display("FAIL b2b_count got %0d/%0d want 3/3", got, sent); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    int stale;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in1 = 25'h11; in2 = 25'h22; sub = 1'b0;
    @(negedge clk);
    in1 = 25'h33; in2 = 25'h44;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight out_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (S !== 25'h0) begin errors++; $display("FAIL rstmid_S got %h want 0", S); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL rstmid_Cout got %b want 0", Cout); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale got %0d beats want 0", stale); end
  endtask

  task automatic test_random10;
    logic [10:0] exp;
    int sent, got;
    bit renew;
    sent = 0; got = 0; renew = 1'b1;
    for (int cyc = 0; cyc < 60000 && got < NB; cyc++) begin
      @(negedge clk);
      if (renew) begin
        in1_10 = 10'($urandom_range(0, 1023));
        in2_10 = 10'($urandom_range(0, 1023));
        sub10  = 1'($urandom_range(0, 1));
        renew  = 1'b0;
      end
      out_ready10 = ($urandom_range(0, 3) != 0);
      in_valid10  = (sent < NB) && ($urandom_range(0, 7) != 0);
      #1;
      if (out_valid10 && out_ready10) begin
        checks++;
        if (exp_q10.size() == 0) begin errors++; $display("FAIL rand_extra got %h want none", {Cout10, S10}); end
        else begin
          exp = exp_q10.pop_front();
          if ({Cout10, S10} !== exp) begin errors++; $display("FAIL rand_data beat %0d got %h want %h", got, {Cout10, S10}, exp); end
        end
        got++;
      end
      if (in_valid10 && in_ready10) begin
        exp_q10.push_back(ref10(in1_10, in2_10, sub10));
        sent++;
        renew = 1'b1;
      end
    end
    checks++;
    if (got !== NB || exp_q10.size() !== 0) begin
      errors++; $display("FAIL rand_count got %0d left %0d want %0d left 0", got, exp_q10.size(), NB);
    end
    @(negedge clk);
    in_valid10 = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0;
    in_valid10 = 1'b0; sub10 = 1'b0; out_ready10 = 1'b1; in1_10 = '0; in2_10 = '0;
    test_reset();
    test_add_carry();
    test_sub();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random10();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
